// File: rtl/core_pkg.sv
// Shared fetch-stage types: address/instruction widths, fetch FSM encoding and
// the prefetch queue entry layout.
package core_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [0:0] {
        FS_IDLE,
        FS_RUN
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc1;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from
// registered storage.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 entry_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flush wins over both push and pop.
    always_comb begin
        do_push = push_i & ~flush_i;
        do_pop  = pop_i & ~flush_i & (count_r != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (do_push && !do_pop) begin
                count_r <= count_r + CW'(1);
            end else if (do_pop && !do_push) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_r[wr_ptr_r] <= entry_i;
        end
    end

    assign head_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle synchronous instruction
// memory and buffers responses in a prefetch queue feeding decode.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               halt_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    output logic               imem_rd_en_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic [PC_W-1:0]    instr_pc1_o,
    output logic               busy_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e  state_r;
    fetch_state_e  state_next;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] inflight_pc_r;
    logic          inflight_r;
    logic          kill_r;
    logic [CW-1:0] count_r;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  new_entry;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= FS_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    always_comb begin
        state_next = state_r;
        unique case (state_r)
            FS_IDLE: if (start_i && !halt_i) state_next = FS_RUN;
            FS_RUN:  if (halt_i)             state_next = FS_IDLE;
            default:                         state_next = FS_IDLE;
        endcase
    end

    // Credit check counts the in-flight read so every response has a free slot.
    always_comb begin
        instr_valid_o = (count_r != '0) & ~redirect_i;
        pop           = instr_valid_o & instr_ready_i;
        occupancy     = {1'b0, count_r} + (CW + 1)'(inflight_r) - (CW + 1)'(pop);
        issue         = (state_r == FS_RUN) & ~redirect_i & (occupancy < (CW + 1)'(DEPTH));
        push          = inflight_r & ~kill_r & ~redirect_i;
        imem_addr_o   = pc_r;
        imem_rd_en_o  = issue;
        busy_o        = (state_r == FS_RUN) | (count_r != '0) | inflight_r;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r          <= '0;
            inflight_pc_r <= '0;
            inflight_r    <= 1'b0;
            kill_r        <= 1'b0;
        end else begin
            inflight_r <= issue;
            kill_r     <= redirect_i & issue;
            if (redirect_i) begin
                pc_r <= redirect_pc_i;
            end else if (issue) begin
                pc_r <= pc_r + 1'b1;
            end
            if (issue) begin
                inflight_pc_r <= pc_r;
            end
        end
    end

    always_comb begin
        new_entry.instr = imem_data_i;
        new_entry.pc    = inflight_pc_r;
        new_entry.pc1   = inflight_pc_r + 1'b1;
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .entry_i (new_entry),
        .head_o  (head),
        .count_o (count_r)
    );

    // Head fields read as zero while the queue is empty.
    always_comb begin
        instr_o     = (count_r != '0) ? head.instr : '0;
        instr_pc_o  = (count_r != '0) ? head.pc    : '0;
        instr_pc1_o = (count_r != '0) ? head.pc1   : '0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit with a 1-cycle synchronous
// instruction memory model returning addr + 0x100.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic [7:0]  instr_pc1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_rd_en_o  (imem_rd_en),
        .imem_data_i   (imem_data),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_pc1_o   (instr_pc1),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= 32'h100 + {24'h0, imem_addr};
    end

    always @(negedge clk) begin
        if (!rst && dut.push && dut.count_r == 2'(DEPTH)) begin
            errors++;
            $display("FAIL push_full t=%0t: push with count %0d, required count < %0d",
                     $time, dut.count_r, DEPTH);
        end
    end

    typedef struct {
        logic       st;
        logic       ht;
        logic       rd;
        logic [7:0] rpc;
        logic       rdy;
        logic       rs;
        logic       e_rd;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_pc;
        logic       e_busy;
    } vec_t;

    function automatic vec_t v(logic st, logic ht, logic rd, logic [7:0] rpc, logic rdy,
                               logic rs, logic e_rd, logic [7:0] e_addr, logic e_valid,
                               logic [7:0] e_pc, logic e_busy);
        vec_t r;
        r.st = st; r.ht = ht; r.rd = rd; r.rpc = rpc; r.rdy = rdy; r.rs = rs;
        r.e_rd = e_rd; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc;
        r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h required %0h", name, idx, act, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        instr_ready = 1'b1;
        // start, halt, redirect, redirect_pc, ready, rst | rd_en, addr, valid, pc, busy
        vecs.push_back(v(1, 0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 8'h00, 0)); // c0 start
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h00, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h01, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h02, 1, 8'h00, 1)); // first valid
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h03, 1, 8'h01, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h04, 1, 8'h02, 1));
        for (int i = 0; i < 6; i++)                                          // stall
            vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,  0, 8'h05, 1, 8'h03, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h05, 1, 8'h03, 1)); // resume
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h06, 1, 8'h04, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h07, 1, 8'h05, 1));
        vecs.push_back(v(0, 0, 1, 8'h40, 1, 0,  0, 8'h08, 0, 8'h00, 1)); // redirect 0x40
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h40, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h41, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h42, 1, 8'h40, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h43, 1, 8'h41, 1));
        vecs.push_back(v(0, 0, 1, 8'h10, 1, 0,  0, 8'h44, 0, 8'h00, 1)); // redirect 0x10
        vecs.push_back(v(0, 0, 1, 8'h20, 1, 0,  0, 8'h10, 0, 8'h00, 1)); // redirect 0x20
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h20, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h21, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h22, 1, 8'h20, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h23, 1, 8'h21, 1));
        vecs.push_back(v(0, 0, 1, 8'hFE, 1, 0,  0, 8'h24, 0, 8'h00, 1)); // redirect 0xFE
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'hFE, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'hFF, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h00, 1, 8'hFE, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h01, 1, 8'hFF, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h02, 1, 8'h00, 1));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0,  0, 8'h03, 1, 8'h01, 1)); // halt
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,  0, 8'h03, 1, 8'h01, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  0, 8'h03, 1, 8'h01, 1)); // drain
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  0, 8'h03, 1, 8'h02, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  0, 8'h03, 0, 8'h00, 0));
        vecs.push_back(v(1, 0, 0, 8'h00, 1, 0,  0, 8'h03, 0, 8'h00, 0)); // restart
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  1, 8'h03, 0, 8'h00, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 1,  1, 8'h04, 0, 8'h00, 1)); // reset, read in flight
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 8'h00, 0));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 8'h00, 0)); // no late push

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rd_en", -1, 32'(imem_rd_en), 32'h0);
        check("reset_addr",  -1, 32'(imem_addr), 32'h0);
        check("reset_valid", -1, 32'(instr_valid), 32'h0);
        check("reset_instr", -1, instr, 32'h0);
        check("reset_busy",  -1, 32'(busy), 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].st; halt = vecs[i].ht; redirect = vecs[i].rd;
            redirect_pc = vecs[i].rpc; instr_ready = vecs[i].rdy; rst = vecs[i].rs;
            #1;
            check("rd_en", i, 32'(imem_rd_en), 32'(vecs[i].e_rd));
            check("addr",  i, 32'(imem_addr), 32'(vecs[i].e_addr));
            check("valid", i, 32'(instr_valid), 32'(vecs[i].e_valid));
            check("busy",  i, 32'(busy), 32'(vecs[i].e_busy));
            if (vecs[i].e_valid) begin
                check("instr", i, instr, 32'h100 + 32'(vecs[i].e_pc));
                check("pc",    i, 32'(instr_pc), 32'(vecs[i].e_pc));
                check("pc1",   i, 32'(instr_pc1), 32'(8'(vecs[i].e_pc + 8'h01)));
            end
        end

        // Post-reset head fields are zero.
        check("post_rst_instr", 100, instr, 32'h0);
        check("post_rst_pc",    100, 32'(instr_pc), 32'h0);
        check("post_rst_pc1",   100, 32'(instr_pc1), 32'h0);

        // halt has priority over start: stays idle, nothing issued.
        @(negedge clk);
        start = 1'b1; halt = 1'b1;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        #1;
        check("halt_prio_rd_en", 101, 32'(imem_rd_en), 32'h0);
        check("halt_prio_busy",  101, 32'(busy), 32'h0);
        @(negedge clk);
        #1;
        check("halt_prio_rd_en2", 102, 32'(imem_rd_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
